// File: rtl/gpio_cfg_regfile.sv
// GPIO-driven configuration register bank: synchronises the PS GPIO bus, decodes byte writes
// into shift-loaded RW registers, trigger pulses and an indirect table port, with registered readback.
module gpio_cfg_regfile #(
  parameter int                  GPIO_W       = 25,
  parameter int                  W_CLK_BIT    = 24,
  parameter int                  ADDR_W       = 16,
  parameter int                  DATA_W       = 8,
  parameter int                  REG_W        = 32,
  parameter int                  NUM_REGS     = 32,
  parameter logic [NUM_REGS-1:0] TRIG_MASK    = 32'h0000_0003,
  parameter int                  NUM_RO       = 16,
  parameter logic [ADDR_W-1:0]   RO_BASE      = 16'h0040,
  parameter logic [ADDR_W-1:0]   IND_ADDR_REG = 16'h0080,
  parameter logic [ADDR_W-1:0]   IND_DATA_REG = 16'h0081
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [GPIO_W-1:0]          gpio_in,
  output logic [NUM_REGS*REG_W-1:0]  regs_flat,
  output logic [NUM_REGS-1:0]        trig_out,
  output logic                       tbl_wr_en,
  output logic [ADDR_W-1:0]          tbl_addr,
  output logic [DATA_W-1:0]          tbl_wr_data,
  input  logic [NUM_RO*REG_W-1:0]    ro_flat,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [REG_W-1:0]           rd_data,
  output logic [15:0]                wr_count,
  output logic                       err_addr
);

  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int RO_IDX_W = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;

  logic [GPIO_W-1:0] g1, g2;
  logic              prev_wclk;
  logic [1:0]        sync_fill;
  logic              st;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic [31:0]       a_ext;
  logic [IDX_W-1:0]  idx;
  logic              is_local, is_trig, is_ind_addr, is_ind_data;
  logic [ADDR_W-1:0] ind_ptr;
  logic [REG_W-1:0]  regs [NUM_REGS];
  logic [REG_W-1:0]  ro_arr [NUM_RO];

  assign a  = g2[ADDR_W-1:0];
  assign d  = g2[ADDR_W+DATA_W-1:ADDR_W];
  assign st = g2[W_CLK_BIT] & ~prev_wclk;

  // prev_wclk stays high until g2 holds a real post-reset sample, so a strobe
  // already high at reset release is treated as old and never writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      g1        <= '0;
      g2        <= '0;
      sync_fill <= '0;
      prev_wclk <= 1'b1;
    end else begin
      g1        <= gpio_in;
      g2        <= g1;
      sync_fill <= {sync_fill[0], 1'b1};
      prev_wclk <= sync_fill[1] ? g2[W_CLK_BIT] : 1'b1;
    end
  end

  assign a_ext       = 32'(a);
  assign idx         = a[IDX_W-1:0];
  assign is_ind_addr = (a == IND_ADDR_REG);
  assign is_ind_data = (a == IND_DATA_REG);
  assign is_local    = (a_ext < 32'(NUM_REGS));
  assign is_trig     = is_local & TRIG_MASK[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (st && !is_ind_addr && !is_ind_data && is_local && !is_trig) begin
      regs[idx] <= REG_W'({regs[idx], d});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_out    <= '0;
      tbl_wr_en   <= 1'b0;
      tbl_addr    <= '0;
      tbl_wr_data <= '0;
      ind_ptr     <= '0;
      wr_count    <= '0;
      err_addr    <= 1'b0;
    end else begin
      trig_out  <= '0;
      tbl_wr_en <= 1'b0;
      if (st) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        if (is_ind_addr) begin
          ind_ptr <= ADDR_W'({ind_ptr, d});
        end else if (is_ind_data) begin
          tbl_wr_en   <= 1'b1;
          tbl_addr    <= ind_ptr;
          tbl_wr_data <= d;
          ind_ptr     <= ind_ptr + ADDR_W'(1);
        end else if (is_trig) begin
          trig_out[idx] <= 1'b1;
        end else if (!is_local) begin
          err_addr <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
    assign regs_flat[i*REG_W +: REG_W] = regs[i];
  end

  for (genvar j = 0; j < NUM_RO; j++) begin : g_ro_in
    assign ro_arr[j] = ro_flat[j*REG_W +: REG_W];
  end

  logic [31:0]         rd_ext, ro_off;
  logic [IDX_W-1:0]    rd_idx;
  logic [RO_IDX_W-1:0] ro_sel;
  logic                rd_local, rd_in_ro;
  logic [REG_W-1:0]    rd_next;

  assign rd_ext   = 32'(rd_addr);
  assign ro_off   = rd_ext - 32'(RO_BASE);
  assign rd_idx   = rd_addr[IDX_W-1:0];
  assign ro_sel   = ro_off[RO_IDX_W-1:0];
  assign rd_local = (rd_ext < 32'(NUM_REGS));
  assign rd_in_ro = (rd_ext >= 32'(RO_BASE)) && (ro_off < 32'(NUM_RO));

  // Mux reads current register state, so a same-cycle write shows up one read later.
  always_comb begin
    rd_next = '0;
    if (rd_local) begin
      rd_next = TRIG_MASK[rd_idx] ? '0 : regs[rd_idx];
    end else if (rd_in_ro) begin
      rd_next = ro_arr[ro_sel];
    end else if (rd_addr == IND_ADDR_REG) begin
      rd_next = REG_W'(ind_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_next;
  end

endmodule

// File: tb/tb_gpio_cfg_regfile.sv
// Self-checking bench for gpio_cfg_regfile: directed vector table, hand-written corner
// sequences and randomized writes against a behavioural register-bank model.
module tb_gpio_cfg_regfile;

  logic          clk = 1'b0;
  logic          rst;
  logic [24:0]   gpio_in;
  logic [1023:0] regs_flat;
  logic [31:0]   trig_out;
  logic          tbl_wr_en;
  logic [15:0]   tbl_addr;
  logic [7:0]    tbl_wr_data;
  logic [511:0]  ro_flat;
  logic [15:0]   rd_addr;
  logic [31:0]   rd_data;
  logic [15:0]   wr_count;
  logic          err_addr;

  gpio_cfg_regfile dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .regs_flat(regs_flat), .trig_out(trig_out),
    .tbl_wr_en(tbl_wr_en), .tbl_addr(tbl_addr), .tbl_wr_data(tbl_wr_data), .ro_flat(ro_flat),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } tbl_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [15:0] rd_a;
    logic [31:0] exp_rd;
    bit          exp_tbl;
    logic [15:0] exp_tbl_a;
    bit          exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the register bank
  logic [31:0] m_regs [32];
  logic [15:0] m_ptr;
  int          m_count;
  bit          m_err;
  logic [31:0] ro_vals [16];
  int          exp_trig [32];
  tbl_t        exp_q [$];

  // Observed pulses
  int   trig_cnt [32];
  tbl_t tbl_q [$];

  always @(negedge clk) begin
    if (tbl_wr_en) tbl_q.push_back('{tbl_addr, tbl_wr_data});
    for (int i = 0; i < 32; i++) if (trig_out[i]) trig_cnt[i]++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    gpio_in = {1'b0, d, a};
    repeat (2) @(negedge clk);
    gpio_in[24] = 1'b1;
    repeat (hold) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    if (m_count < 65535) m_count++;
    if (a == 16'h0080) begin
      m_ptr = (m_ptr << 8) | 16'(d);
    end else if (a == 16'h0081) begin
      exp_q.push_back('{m_ptr, d});
      m_ptr = m_ptr + 16'd1;
    end else if (a < 16'd2) begin
      exp_trig[a]++;
    end else if (a < 16'd32) begin
      m_regs[a] = (m_regs[a] << 8) | 32'(d);
    end else begin
      m_err = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (a < 16'd2) return 32'h0;
    if (a < 16'd32) return m_regs[a];
    if (a >= 16'h0040 && a < 16'h0050) return ro_vals[a - 16'h0040];
    if (a == 16'h0080) return 32'(m_ptr);
    return 32'h0;
  endfunction

  task automatic drive_ro();
    for (int i = 0; i < 16; i++) ro_flat[i*32 +: 32] = ro_vals[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gpio_in = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      exp_trig[i] = 0;
      trig_cnt[i] = 0;
    end
    m_ptr = '0;
    m_count = 0;
    m_err = 1'b0;
    exp_q.delete();
    tbl_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    checkOutput($sformatf("rd_data@%h", a), 64'(rd_data), 64'(exp));
  endtask

  task automatic verify_state(input string tag);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("%s reg%0d", tag, i), 64'(regs_flat[i*32 +: 32]), 64'(m_regs[i]));
    checkOutput({tag, " wr_count"}, 64'(wr_count), 64'(m_count));
    checkOutput({tag, " err_addr"}, 64'(err_addr), 64'(m_err));
    checkOutput({tag, " trig0"}, 64'(trig_cnt[0]), 64'(exp_trig[0]));
    checkOutput({tag, " trig1"}, 64'(trig_cnt[1]), 64'(exp_trig[1]));
    checkOutput({tag, " trig_idle"}, 64'(trig_out), 64'h0);
    checkOutput({tag, " tbl_idle"}, 64'(tbl_wr_en), 64'h0);
    checkOutput({tag, " tbl_count"}, 64'(tbl_q.size()), 64'(exp_q.size()));
    while (tbl_q.size() > 0 && exp_q.size() > 0) begin
      tbl_t o = tbl_q.pop_front();
      tbl_t e = exp_q.pop_front();
      checkOutput({tag, " tbl_entry"}, {40'h0, o.a, o.d}, {40'h0, e.a, e.d});
    end
    tbl_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{16'h0005, 8'h12, 16'h0005, 32'h0000_0012, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{16'h0005, 8'h34, 16'h0005, 32'h0000_1234, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{16'h0005, 8'h56, 16'h0005, 32'h0012_3456, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{16'h0005, 8'h78, 16'h0005, 32'h1234_5678, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{16'h0080, 8'h00, 16'h0080, 32'h0000_0000, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{16'h0080, 8'hFE, 16'h0080, 32'h0000_00FE, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{16'h0081, 8'h0A, 16'h0080, 32'h0000_00FF, 1'b1, 16'h00FE, 1'b0};
    vecs[7]  = '{16'h0081, 8'h0B, 16'h0080, 32'h0000_0100, 1'b1, 16'h00FF, 1'b0};
    vecs[8]  = '{16'h0081, 8'h0C, 16'h0080, 32'h0000_0101, 1'b1, 16'h0100, 1'b0};
    vecs[9]  = '{16'h0080, 8'hFF, 16'h0080, 32'h0000_01FF, 1'b0, 16'h0000, 1'b0};
    vecs[10] = '{16'h0080, 8'hFF, 16'h0080, 32'h0000_FFFF, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{16'h0081, 8'h5A, 16'h0080, 32'h0000_0000, 1'b1, 16'hFFFF, 1'b0};
    vecs[12] = '{16'h0045, 8'h11, 16'h0045, 32'hDEAD_BEEF, 1'b0, 16'h0000, 1'b1};
    vecs[13] = '{16'h0200, 8'h22, 16'h0005, 32'h1234_5678, 1'b0, 16'h0000, 1'b1};

    for (int i = 0; i < 16; i++) ro_vals[i] = '0;
    ro_vals[5] = 32'hDEAD_BEEF;
    drive_ro();

    // Reset state, checked while reset is still applied
    rst = 1'b1;
    gpio_in = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst regs_flat_lo", regs_flat[63:0], 64'h0);
    checkOutput("rst regs_flat_or", 64'(|regs_flat), 64'h0);
    checkOutput("rst trig_out", 64'(trig_out), 64'h0);
    checkOutput("rst tbl", {31'h0, tbl_wr_en, 8'h0, tbl_addr, tbl_wr_data}, 64'h0);
    checkOutput("rst rd_data", 64'(rd_data), 64'h0);
    checkOutput("rst wr_count", 64'(wr_count), 64'h0);
    checkOutput("rst err_addr", 64'(err_addr), 64'h0);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].a, vecs[i].d, 1);
      model_write(vecs[i].a, vecs[i].d);
      checkOutput($sformatf("vec%0d tbl_count", i), 64'(tbl_q.size()), 64'(vecs[i].exp_tbl));
      if (vecs[i].exp_tbl && tbl_q.size() > 0)
        checkOutput($sformatf("vec%0d tbl_entry", i), {40'h0, tbl_q[0].a, tbl_q[0].d},
                    {40'h0, vecs[i].exp_tbl_a, vecs[i].d});
      checkOutput($sformatf("vec%0d err_addr", i), 64'(err_addr), 64'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d wr_count", i), 64'(wr_count), 64'(i + 1));
      do_read(vecs[i].rd_a, vecs[i].exp_rd);
      verify_state($sformatf("vec%0d", i));
    end

    // Trigger address with w_clk held high for many cycles
    applyStimulus(16'h0000, 8'hFF, 10);
    model_write(16'h0000, 8'hFF);
    checkOutput("trig0 single pulse", 64'(trig_cnt[0]), 64'd1);
    checkOutput("trig wr_count", 64'(wr_count), 64'd15);
    do_read(16'h0000, 32'h0);
    verify_state("trig");

    // Randomized writes against the model
    do_reset();
    for (int i = 0; i < 16; i++) ro_vals[i] = $urandom;
    drive_ro();
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      logic [15:0] ra;
      logic [7:0]  d;
      int          kind;
      kind = $urandom_range(0, 6);
      d = 8'($urandom);
      case (kind)
        0, 1:    a = 16'($urandom_range(0, 31));
        2:       a = 16'h0080;
        3, 4:    a = 16'h0081;
        5:       a = 16'h0040 + 16'($urandom_range(0, 15));
        default: a = 16'($urandom_range(16'h0100, 16'hFFFF));
      endcase
      applyStimulus(a, d, $urandom_range(1, 4));
      model_write(a, d);
      verify_state($sformatf("rand%0d", n));
      case ($urandom_range(0, 3))
        0:       ra = 16'($urandom_range(0, 31));
        1:       ra = 16'h0040 + 16'($urandom_range(0, 15));
        2:       ra = 16'h0080;
        default: ra = 16'($urandom_range(16'h0081, 16'h0300));
      endcase
      do_read(ra, model_read(ra));
    end

    // w_clk already high across reset release must not write
    rst = 1'b1;
    gpio_in = {1'b1, 8'h55, 16'h0005};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("held wclk wr_count", 64'(wr_count), 64'h0);
    checkOutput("held wclk reg5", 64'(regs_flat[5*32 +: 32]), 64'h0);
    gpio_in[24] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a partial shift-in
    applyStimulus(16'h0003, 8'hAA, 1);
    applyStimulus(16'h0003, 8'hBB, 1);
    checkOutput("partial reg3", 64'(regs_flat[3*32 +: 32]), 64'h0000_AABB);
    checkOutput("partial wr_count", 64'(wr_count), 64'd2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst regs_flat", 64'(|regs_flat), 64'h0);
    checkOutput("midrst wr_count", 64'(wr_count), 64'h0);
    checkOutput("midrst err_trig_tbl", {30'h0, err_addr, tbl_wr_en, trig_out}, 64'h0);
    checkOutput("midrst rd_data", 64'(rd_data), 64'h0);
    do_reset();
    do_read(16'h0080, 32'h0);
    do_read(16'h0003, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
